// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end: receiver states,
// scan codes of the game keys and the default mid-frame timeout.
package ps2_pkg;

   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_DATA   = 2'd1,
      RX_PARITY = 2'd2,
      RX_STOP   = 2'd3
   } rx_state_e;

   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_Z     = 8'h1A;
   localparam logic [7:0] SC_X     = 8'h22;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   // Arrow keys, only meaningful after an 0xE0 prefix
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   localparam int unsigned TIMEOUT_DEFAULT = 200000;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit frame FSM
// with odd-parity / stop-bit check and a mid-frame timeout.
//   state     | meaning
//   RX_IDLE   | waiting for a start bit (sampled 0)
//   RX_DATA   | shifting 8 data bits, LSB first
//   RX_PARITY | capturing the parity bit
//   RX_STOP   | checking stop bit and parity, then back to idle
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       frame_err_o
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

   logic [2:0]    clk_sync_q;
   logic [1:0]    data_sync_q;
   rx_state_e     state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic          parity_q, parity_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          frame_err_q, frame_err_d;
   logic          fall;
   logic          data_s;

   assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
   assign data_s = data_sync_q[1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         clk_sync_q  <= '0;
         data_sync_q <= '0;
         state_q     <= RX_IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         parity_q    <= 1'b0;
         tmo_q       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
         data_sync_q <= {data_sync_q[0], ps2_data_i};
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         parity_q    <= parity_d;
         tmo_q       <= tmo_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      parity_d     = parity_q;
      tmo_d        = tmo_q;
      frame_err_d  = 1'b0;
      byte_valid_o = 1'b0;

      unique case (state_q)
         RX_IDLE: begin
            tmo_d = TMO_LOAD;
            if (fall && !data_s) begin
               state_d   = RX_DATA;
               bit_cnt_d = '0;
            end
         end
         RX_DATA: begin
            if (fall) begin
               shift_d   = {data_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
            end
         end
         RX_PARITY: begin
            if (fall) begin
               parity_d = data_s;
               state_d  = RX_STOP;
            end
         end
         RX_STOP: begin
            if (fall) begin
               if (data_s && (^{shift_q, parity_q})) byte_valid_o = 1'b1;
               else                                  frame_err_d  = 1'b1;
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase

      // Down-counting watchdog, re-armed by every falling edge inside a frame
      if (state_q != RX_IDLE) begin
         if (fall) begin
            tmo_d = TMO_LOAD;
         end else if (tmo_q == '0) begin
            state_d     = RX_IDLE;
            frame_err_d = 1'b1;
         end else begin
            tmo_d = tmo_q - TW'(1);
         end
      end
   end

   assign byte_o      = shift_q;
   assign frame_err_o = frame_err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// Scan-code decoder keeping held-level bits for the STG game keys.
// Optional build macro PS2_EXT_ARROWS_EN adds arrow keys OR-ed into WASD.
module ps2_key_tracker
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       key_w,
   output logic       key_a,
   output logic       key_s,
   output logic       key_d,
   output logic       key_z,
   output logic       key_x,
   output logic       key_enter,
   output logic       enter_pulse,
   output logic       bomb_pulse,
   output logic [7:0] last_code,
   output logic       frame_err
);

   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_err;

   ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk          (clk),
      .rstn         (rstn),
      .ps2_clk_i    (ps2_clk),
      .ps2_data_i   (ps2_data),
      .byte_o       (rx_byte),
      .byte_valid_o (rx_valid),
      .frame_err_o  (rx_err)
   );

   logic w_q, w_d, a_q, a_d, s_q, s_d, d_q, d_d;
   logic z_q, z_d, x_q, x_d, ent_q, ent_d;
   logic ent_pls_q, ent_pls_d, bomb_pls_q, bomb_pls_d;
   logic brk_q, brk_d, ext_q, ext_d;
   logic [7:0] last_q, last_d;
   logic key_byte;

   // A key byte is any valid byte that is not a prefix
   assign key_byte = rx_valid && (rx_byte != SC_BREAK) && (rx_byte != SC_EXT);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         w_q <= 1'b0; a_q <= 1'b0; s_q <= 1'b0; d_q <= 1'b0;
         z_q <= 1'b0; x_q <= 1'b0; ent_q <= 1'b0;
         ent_pls_q  <= 1'b0;
         bomb_pls_q <= 1'b0;
         brk_q      <= 1'b0;
         ext_q      <= 1'b0;
         last_q     <= '0;
      end else begin
         w_q <= w_d; a_q <= a_d; s_q <= s_d; d_q <= d_d;
         z_q <= z_d; x_q <= x_d; ent_q <= ent_d;
         ent_pls_q  <= ent_pls_d;
         bomb_pls_q <= bomb_pls_d;
         brk_q      <= brk_d;
         ext_q      <= ext_d;
         last_q     <= last_d;
      end
   end

   always_comb begin
      w_d = w_q; a_d = a_q; s_d = s_q; d_d = d_q;
      z_d = z_q; x_d = x_q; ent_d = ent_q;
      ent_pls_d  = 1'b0;
      bomb_pls_d = 1'b0;
      brk_d      = brk_q;
      ext_d      = ext_q;
      last_d     = last_q;

      if (rx_valid) begin
         last_d = rx_byte;
         if (rx_byte == SC_BREAK) begin
            brk_d = 1'b1;
         end else if (rx_byte == SC_EXT) begin
            ext_d = 1'b1;
         end else begin
            brk_d = 1'b0;
            ext_d = 1'b0;
            if (!ext_q) begin
               case (rx_byte)
                  SC_W: w_d = ~brk_q;
                  SC_A: a_d = ~brk_q;
                  SC_S: s_d = ~brk_q;
                  SC_D: d_d = ~brk_q;
                  SC_Z: z_d = ~brk_q;
                  SC_X: begin
                     x_d        = ~brk_q;
                     bomb_pls_d = ~brk_q & ~x_q;
                  end
                  SC_ENTER: begin
                     ent_d     = ~brk_q;
                     ent_pls_d = ~brk_q & ~ent_q;
                  end
                  default: ;
               endcase
            end
         end
      end else if (rx_err) begin
         brk_d = 1'b0;
         ext_d = 1'b0;
      end
   end

`ifdef PS2_EXT_ARROWS_EN
   logic up_q, up_d, dn_q, dn_d, lf_q, lf_d, rt_q, rt_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         up_q <= 1'b0; dn_q <= 1'b0; lf_q <= 1'b0; rt_q <= 1'b0;
      end else begin
         up_q <= up_d; dn_q <= dn_d; lf_q <= lf_d; rt_q <= rt_d;
      end
   end

   always_comb begin
      up_d = up_q; dn_d = dn_q; lf_d = lf_q; rt_d = rt_q;
      if (key_byte && ext_q) begin
         case (rx_byte)
            SC_UP:    up_d = ~brk_q;
            SC_DOWN:  dn_d = ~brk_q;
            SC_LEFT:  lf_d = ~brk_q;
            SC_RIGHT: rt_d = ~brk_q;
            default: ;
         endcase
      end
   end

   assign key_w = w_q | up_q;
   assign key_a = a_q | lf_q;
   assign key_s = s_q | dn_q;
   assign key_d = d_q | rt_q;
`else
   logic unused_key_byte;
   assign unused_key_byte = key_byte;

   assign key_w = w_q;
   assign key_a = a_q;
   assign key_s = s_q;
   assign key_d = d_q;
`endif

   assign key_z       = z_q;
   assign key_x       = x_q;
   assign key_enter   = ent_q;
   assign enter_pulse = ent_pls_q;
   assign bomb_pulse  = bomb_pls_q;
   assign last_code   = last_q;
   assign frame_err   = rx_err;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: bit-banged PS/2 frames, hand-computed expectations.
module tb_ps2_key_tracker;

   localparam int unsigned TMO  = 500;
   localparam int          HALF = 20;
`ifdef PS2_EXT_ARROWS_EN
   localparam logic ARROWS = 1'b1;
`else
   localparam logic ARROWS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       key_w, key_a, key_s, key_d, key_z, key_x, key_enter;
   logic       enter_pulse, bomb_pulse, frame_err;
   logic [7:0] last_code;

   int vectors = 0;
   int miscompares = 0;
   int enter_cnt = 0;
   int bomb_cnt = 0;
   int err_cnt = 0;
   int e0, b0, f0;

   ps2_key_tracker #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .key_w       (key_w),
      .key_a       (key_a),
      .key_s       (key_s),
      .key_d       (key_d),
      .key_z       (key_z),
      .key_x       (key_x),
      .key_enter   (key_enter),
      .enter_pulse (enter_pulse),
      .bomb_pulse  (bomb_pulse),
      .last_code   (last_code),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   // Strobe cycle counters, sampled away from the active edge
   always @(negedge clk) begin
      if (enter_pulse) enter_cnt++;
      if (bomb_pulse)  bomb_cnt++;
      if (frame_err)   err_cnt++;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: observed no finish, expected finish before 2ms");
      $fatal(1, "watchdog expired");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      wait_clk(HALF);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ bad_par);
      ps2_bit(1'b1);
      ps2_data = 1'b1;
      wait_clk(HALF);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] outs;
      wait_clk(4);
      @(negedge clk);
      outs = {key_w, key_a, key_s, key_d, key_z, key_x, key_enter, frame_err};
      chk8("reset_keys", outs, 8'h00);
      chk8("reset_last", last_code, 8'h00);
      rstn = 1'b1;
      wait_clk(10);

      // W make / break
      send_frame(8'h1D, 1'b0);
      chk1("w_make", key_w, 1'b1);
      chk8("w_make_last", last_code, 8'h1D);
      send_frame(8'hF0, 1'b0);
      chk8("brk_last", last_code, 8'hF0);
      chk1("w_held_after_f0", key_w, 1'b1);
      send_frame(8'h1D, 1'b0);
      chk1("w_break", key_w, 1'b0);
      chk8("w_break_last", last_code, 8'h1D);

      // Enter typematic then break, X make
      e0 = enter_cnt;
      repeat (3) send_frame(8'h5A, 1'b0);
      chk1("enter_held", key_enter, 1'b1);
      chkn("enter_pulses", enter_cnt - e0, 1);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h5A, 1'b0);
      chk1("enter_break", key_enter, 1'b0);
      chkn("enter_pulses_brk", enter_cnt - e0, 1);
      b0 = bomb_cnt;
      send_frame(8'h22, 1'b0);
      chk1("x_held", key_x, 1'b1);
      chkn("bomb_pulses", bomb_cnt - b0, 1);
      send_frame(8'h22, 1'b0);
      chkn("bomb_pulses_rep", bomb_cnt - b0, 1);
      send_frame(8'h1A, 1'b0);
      chk1("z_held", key_z, 1'b1);

      // Bad parity
      f0 = err_cnt;
      send_frame(8'h1C, 1'b1);
      chkn("parity_err", err_cnt - f0, 1);
      chk1("a_after_bad", key_a, 1'b0);
      send_frame(8'h1C, 1'b0);
      chk1("a_after_good", key_a, 1'b1);
      chkn("no_err_good", err_cnt - f0, 1);

      // Timeout after 4 data bits of 0x23 (bits 1,1,0,0)
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b0);
      ps2_data = 1'b1;
      wait_clk(TMO + 100);
      @(negedge clk);
      chkn("timeout_err", err_cnt - f0, 2);
      chk1("d_after_timeout", key_d, 1'b0);
      chk1("a_kept_timeout", key_a, 1'b1);
      send_frame(8'h23, 1'b0);
      chk1("d_after_frame", key_d, 1'b1);
      chk8("d_last", last_code, 8'h23);
      chkn("no_err_d", err_cnt - f0, 2);

      // Extended up arrow
      send_frame(8'hE0, 1'b0);
      send_frame(8'h75, 1'b0);
      chk1("ext_up", key_w, ARROWS);
      chk8("ext_last", last_code, 8'h75);
      send_frame(8'h1D, 1'b0);
      chk1("w_after_ext", key_w, 1'b1);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1D, 1'b0);
      chk1("w_brk_after_ext", key_w, ARROWS);
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      chk1("up_release", key_w, 1'b0);

      // S held, reset mid-frame
      send_frame(8'h1B, 1'b0);
      chk1("s_held", key_s, 1'b1);
      f0 = err_cnt;
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      outs = {key_w, key_a, key_s, key_d, key_z, key_x, key_enter, frame_err};
      chk8("rst_keys", outs, 8'h00);
      chk8("rst_last", last_code, 8'h00);
      chk8("rst_pulses", {6'b0, enter_pulse, bomb_pulse}, 8'h00);
      wait_clk(5);
      rstn = 1'b1;
      ps2_data = 1'b1;
      wait_clk(TMO + 50);
      @(negedge clk);
      chkn("rst_no_err", err_cnt - f0, 0);
      send_frame(8'h1B, 1'b0);
      chk1("s_after_rst", key_s, 1'b1);
      chk8("last_after_rst", last_code, 8'h1B);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
